// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants for the UART command receiver: ASCII codes, channel limit, FSM encodings.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package uart_cmd_rx_pkg;

    // Command bytes recognised by the parser
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;

    // Highest selectable measurement channel (channels 0..12)
    localparam int MAX_CHANNEL = 12;

    // Width used for the two-digit value; 99 needs 7 bits, so no wrap can fake a legal channel
    localparam int VAL_W = 7;

    // Serial receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Command parser states
    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_D1   = 3'd1;
    localparam logic [2:0] P_D2   = 3'd2;
    localparam logic [2:0] P_CR   = 3'd3;
    localparam logic [2:0] P_RCR  = 3'd4;

    // True for ASCII '0'..'9'
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    // Numeric value of an ASCII digit (only meaningful when is_digit is true)
    function automatic logic [3:0] digit_val(input logic [7:0] b);
        return 4'(b - ASCII_0);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling baud tick, start/data/stop FSM.
// Latency: dout/dout_valid (or frame_err) issue at the middle of the stop bit.
// Backpressure: none; each frame produces exactly one single-cycle pulse that must be taken.
module uart_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 212,
    parameter int DVSR_BIT = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            dout_valid,
    output logic            frame_err
);

    // Bit counter must reach DBIT-1; tick counter must reach 15 and SB_TICK-1
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int SMAX = (SB_TICK > 16) ? (SB_TICK - 1) : 15;
    localparam int SW   = $clog2(SMAX + 1);

    logic [1:0]          sync_q;
    logic                rx_s;
    logic [DVSR_BIT-1:0] baud_cnt;
    logic                tick;
    logic [1:0]          state;
    logic [SW-1:0]       s;
    logic [NW-1:0]       n;
    logic [DBIT-1:0]     shreg;

    // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    // Free-running baud divider: one-cycle tick every DVSR+1 clocks (16 ticks per bit)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + DVSR_BIT'(1);
        end
    end

    assign tick = (baud_cnt == DVSR_BIT'(DVSR));

    // Frame FSM: confirm start at mid-bit (s=7), then sample every 16 ticks so each data bit and
    // the stop bit are taken at their centre; returning to IDLE at mid-stop lets a directly
    // following start edge be caught
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            s          <= '0;
            n          <= '0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state <= RX_START;
                        s     <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (s == SW'(7)) begin
                            if (!rx_s) begin
                                state <= RX_DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                // Line went high again before mid-start: treat as a glitch
                                state <= RX_IDLE;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (s == SW'(15)) begin
                            s     <= '0;
                            shreg <= {rx_s, shreg[DBIT-1:1]};
                            if (n == NW'(DBIT - 1)) begin
                                state <= RX_STOP;
                            end else begin
                                n <= n + NW'(1);
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (s == SW'(SB_TICK - 1)) begin
                            if (rx_s) begin
                                dout       <= shreg;
                                dout_valid <= 1'b1;
                            end else begin
                                // Stop bit low: report and keep the previous good byte
                                frame_err <= 1'b1;
                            end
                            state <= RX_IDLE;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command front end: receives bytes and decodes "Snn\r" channel select and "R\r" dump request.
// Latency: sel_valid/dump_req/cmd_err one clk after rx_byte_valid of the terminating byte.
// Backpressure: none; all outputs are single-cycle pulses that the consumer must take.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 212,
    parameter int DVSR_BIT = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err,
    output logic [3:0] sel_channel,
    output logic       sel_valid,
    output logic       dump_req,
    output logic       cmd_err
);

    logic [DBIT-1:0]  rx_data;
    logic [2:0]       p_state;
    logic [3:0]       tens;
    logic [3:0]       units;
    logic [VAL_W-1:0] value;

    uart_rx #(
        .DBIT     (DBIT),
        .SB_TICK  (SB_TICK),
        .DVSR     (DVSR),
        .DVSR_BIT (DVSR_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .dout       (rx_data),
        .dout_valid (rx_byte_valid),
        .frame_err  (frame_err)
    );

    assign rx_byte = 8'(rx_data);

    // Two-digit value computed wide so "13".."99" are rejected rather than aliasing into 0..15
    assign value = VAL_W'(tens) * VAL_W'(10) + VAL_W'(units);

    // Command parser: steps only on a received byte; any unexpected byte aborts to P_IDLE with
    // cmd_err (it is not re-parsed), a framing error aborts silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state     <= P_IDLE;
            tens        <= '0;
            units       <= '0;
            sel_channel <= '0;
            sel_valid   <= 1'b0;
            dump_req    <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            sel_valid <= 1'b0;
            dump_req  <= 1'b0;
            cmd_err   <= 1'b0;
            if (frame_err) begin
                p_state <= P_IDLE;
            end else if (rx_byte_valid) begin
                case (p_state)
                    P_IDLE: begin
                        if (rx_byte == ASCII_S) begin
                            p_state <= P_D1;
                        end else if (rx_byte == ASCII_R) begin
                            p_state <= P_RCR;
                        end else if ((rx_byte != ASCII_CR) && (rx_byte != ASCII_LF)) begin
                            cmd_err <= 1'b1;
                        end
                    end
                    P_D1: begin
                        if (is_digit(rx_byte)) begin
                            tens    <= digit_val(rx_byte);
                            p_state <= P_D2;
                        end else begin
                            cmd_err <= 1'b1;
                            p_state <= P_IDLE;
                        end
                    end
                    P_D2: begin
                        if (is_digit(rx_byte)) begin
                            units   <= digit_val(rx_byte);
                            p_state <= P_CR;
                        end else begin
                            cmd_err <= 1'b1;
                            p_state <= P_IDLE;
                        end
                    end
                    P_CR: begin
                        if (rx_byte == ASCII_CR) begin
                            if (value <= VAL_W'(MAX_CHANNEL)) begin
                                sel_channel <= value[3:0];
                                sel_valid   <= 1'b1;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                        end else begin
                            cmd_err <= 1'b1;
                        end
                        p_state <= P_IDLE;
                    end
                    P_RCR: begin
                        if (rx_byte == ASCII_CR) begin
                            dump_req <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                        p_state <= P_IDLE;
                    end
                    default: begin
                        p_state <= P_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
